// File: rtl/seq_array_multiplier.sv
// Sequential shift-add WIDTH x WIDTH multiplier, one multiplier bit per clock, start/done handshake.
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined (adds signed_mode port).
module seq_array_multiplier #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic                 signed_mode,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic [WIDTH:0]    mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_q, neg_d;

   logic [WIDTH:0]    mag_a, mag_b;
   logic              neg_start;
   logic              take;
   logic [PW-1:0]     acc_sum;
   logic [PW-1:0]     result;

`ifdef SEQ_MULT_SIGNED_EN
   // Magnitudes need WIDTH+1 bits so that -2^(WIDTH-1) is representable.
   always_comb begin
      mag_a     = {1'b0, a};
      mag_b     = {1'b0, b};
      neg_start = 1'b0;
      if (signed_mode) begin
         if (a[WIDTH-1]) mag_a = -{a[WIDTH-1], a};
         if (b[WIDTH-1]) mag_b = -{b[WIDTH-1], b};
         neg_start = a[WIDTH-1] ^ b[WIDTH-1];
      end
   end
`else
   assign mag_a     = {1'b0, a};
   assign mag_b     = {1'b0, b};
   assign neg_start = 1'b0;
`endif

   assign take    = ena && start && ((state_q == IDLE) || (state_q == DONE));
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign result  = neg_q ? -acc_sum : acc_sum;

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      product_d = product_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      if (ena) begin
         case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
               acc_d    = acc_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  product_d = result;
                  state_d   = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
      // A new request (from IDLE or DONE) overrides the default transition.
      if (take) begin
         mcand_d  = PW'(mag_a);
         mplier_d = mag_b;
         acc_d    = '0;
         cnt_d    = '0;
         neg_d    = neg_start;
         state_d  = RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         acc_q     <= '0;
         product_q <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
      end
   end

   assign busy    = (state_q == RUN);
   assign done    = (state_q == DONE);
   assign product = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Self-checking bench for seq_array_multiplier: WIDTH=4 and WIDTH=8 instances against an arithmetic model.
module tb_seq_array_multiplier;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       ena4, start4, busy4, done4;
   logic [3:0] a4, b4;
   logic [7:0] prod4;
   logic       ena8, start8, busy8, done8;
   logic [7:0] a8, b8;
   logic [15:0] prod8;
`ifdef SEQ_MULT_SIGNED_EN
   logic       sm4, sm8;
`endif

   int total = 0;
   int bad   = 0;
   logic [7:0]  last4;
   logic [15:0] last8;

   seq_array_multiplier #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena4), .start(start4), .a(a4), .b(b4),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm4),
`endif
      .busy(busy4), .done(done4), .product(prod4)
   );

   seq_array_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .ena(ena8), .start(start8), .a(a8), .b(b8),
`ifdef SEQ_MULT_SIGNED_EN
      .signed_mode(sm8),
`endif
      .busy(busy8), .done(done8), .product(prod8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One WIDTH=4 operation; random starts during RUN must be ignored.
   task automatic op4(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] exp;
      exp = 8'(a) * 8'(b);
`ifdef SEQ_MULT_SIGNED_EN
      if (sm4) exp = 8'($signed({{4{a[3]}}, a}) * $signed({{4{b[3]}}, b}));
`endif
      a4 = a; b4 = b; start4 = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("run4_busy", 32'(busy4), 32'(1));
         chk("run4_done", 32'(done4), 32'(0));
         chk("run4_hold", 32'(prod4), 32'(last4));
         start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
         tick();
      end
      start4 = 1'b0;
      chk("done4", 32'(done4), 32'(1));
      chk("busy4_off", 32'(busy4), 32'(0));
      chk("prod4", 32'(prod4), 32'(exp));
      $display("op w=4 a=%0d b=%0d product=%0h expected=%0h", a, b, prod4, exp);
      last4 = exp;
      tick();
      chk("done4_drop", 32'(done4), 32'(0));
   endtask

   // One WIDTH=8 operation with an optional ena=0 stall mid-RUN.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input int stall);
      logic [15:0] exp;
      exp = 16'(a) * 16'(b);
      a8 = a; b8 = b; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int c = 0; c < 8 + stall; c++) begin
         chk("run8_busy", 32'(busy8), 32'(1));
         chk("run8_done", 32'(done8), 32'(0));
         chk("run8_hold", 32'(prod8), 32'(last8));
         ena8 = !(c >= 3 && c < 3 + stall);
         tick();
      end
      ena8 = 1'b1;
      chk("done8", 32'(done8), 32'(1));
      chk("prod8", 32'(prod8), 32'(exp));
      $display("op w=8 a=%0d b=%0d stall=%0d product=%0h expected=%0h", a, b, stall, prod8, exp);
      last8 = exp;
      if (stall > 0) begin
         ena8 = 1'b0;
         repeat (2) begin
            tick();
            chk("done8_stretch", 32'(done8), 32'(1));
         end
         ena8 = 1'b1;
      end
      tick();
      chk("done8_drop", 32'(done8), 32'(0));
   endtask

   initial begin
      ena4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
      ena8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
`ifdef SEQ_MULT_SIGNED_EN
      sm4 = 1'b0; sm8 = 1'b0;
`endif
      last4 = '0; last8 = '0;

      repeat (2) tick();
      chk("rst_busy", 32'(busy4), 32'(0));
      chk("rst_done", 32'(done4), 32'(0));
      chk("rst_prod4", 32'(prod4), 32'(0));
      chk("rst_prod8", 32'(prod8), 32'(0));
      rst_n = 1'b1;
      tick();
      chk("idle_done", 32'(done4), 32'(0));

      op4(4'd15, 4'd15);
      op4(4'd9, 4'd0);
      op4(4'd0, 4'd13);
      repeat (8) op4(4'($urandom), 4'($urandom));

      // start held high: 3*5 then 7*6 offered during the DONE cycle
      a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
      tick();
      repeat (3) begin
         tick();
         chk("b2b_busy", 32'(busy4), 32'(1));
      end
      tick();
      chk("b2b_done1", 32'(done4), 32'(1));
      chk("b2b_prod1", 32'(prod4), 32'(15));
      a4 = 4'd7; b4 = 4'd6;
      tick();
      chk("b2b_dead", 32'(done4), 32'(0));
      chk("b2b_rerun", 32'(busy4), 32'(1));
      chk("b2b_keep", 32'(prod4), 32'(15));
      repeat (3) begin
         tick();
         chk("b2b_busy2", 32'(done4), 32'(0));
      end
      tick();
      start4 = 1'b0;
      chk("b2b_done2", 32'(done4), 32'(1));
      chk("b2b_prod2", 32'(prod4), 32'(42));
      $display("op w=4 back-to-back product=%0h expected=2a", prod4);
      last4 = 8'd42;
      tick();

      // asynchronous reset in the middle of RUN
      a4 = 4'd12; b4 = 4'd11; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy4), 32'(0));
      chk("mid_rst_done", 32'(done4), 32'(0));
      chk("mid_rst_prod", 32'(prod4), 32'(0));
      tick();
      rst_n = 1'b1;
      last4 = '0; last8 = '0;
      repeat (6) begin
         tick();
         chk("post_rst_idle", 32'(done4 | busy4), 32'(0));
      end
      $display("op w=4 reset mid-run product=%0h", prod4);

      op8(8'($urandom), 8'($urandom), 0);
      op8(8'd200, 8'd250, 3);
      op8(8'd255, 8'd255, 0);

`ifdef SEQ_MULT_SIGNED_EN
      sm4 = 1'b1;
      op4(4'b1000, 4'b0111);
      op4(4'b1000, 4'b1000);
      repeat (6) op4(4'($urandom), 4'($urandom));
      sm4 = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
